// File: rtl/hv_alu_ctrl.sv
// Hypervector ALU sequencer: small register file, command handshake, iterated
// bind/permute with result feedback, and a streamed result port.
module hv_alu_ctrl #(
  parameter int unsigned HVDimension  = 512,
  parameter int unsigned NumRegs      = 4,
  parameter int unsigned RegAddrWidth = $clog2(NumRegs),
  parameter int unsigned MaxShiftAmt  = 128,
  parameter int unsigned PermuteWidth = $clog2(MaxShiftAmt),
  parameter int unsigned IterWidth    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // Register load port
  input  logic                    ld_valid_i,
  input  logic [RegAddrWidth-1:0] ld_addr_i,
  input  logic [HVDimension-1:0]  ld_data_i,
  // Command port
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_op_i,
  input  logic [RegAddrWidth-1:0] cmd_src_a_i,
  input  logic [RegAddrWidth-1:0] cmd_src_b_i,
  input  logic [RegAddrWidth-1:0] cmd_dst_i,
  input  logic [PermuteWidth-1:0] cmd_shift_amt_i,
  input  logic [IterWidth-1:0]    cmd_iter_i,
  input  logic                    cmd_out_i,
  // Result port
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [HVDimension-1:0]  res_data_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StOut
  } state_e;

  localparam logic [1:0] OpXor = 2'd0;
  localparam logic [1:0] OpAnd = 2'd1;
  localparam logic [1:0] OpOr  = 2'd2;

  state_e                  state_q, state_d;
  logic [1:0]              op_q;
  logic [RegAddrWidth-1:0] src_a_q, src_b_q, dst_q;
  logic [PermuteWidth-1:0] shamt_q;
  logic [IterWidth-1:0]    iter_q;
  logic                    out_q;
  logic [IterWidth-1:0]    cnt_q, cnt_d;
  logic [HVDimension-1:0]  res_q;
  logic [HVDimension-1:0]  rf_q [NumRegs];

  logic                     cmd_accept;
  logic                     exec_we;
  logic                     last_iter;
  logic [HVDimension-1:0]   alu_a, alu_b, alu_res;
  logic [2*HVDimension-1:0] rot_wide;

  assign cmd_accept = (state_q == StIdle) && cmd_valid_i;
  assign exec_we    = (state_q == StExec);
  assign last_iter  = (cnt_q == iter_q);

  // Iteration 0 reads the named source; later iterations feed back the previous result.
  assign alu_a = (cnt_q == '0) ? rf_q[src_a_q] : rf_q[dst_q];
  assign alu_b = rf_q[src_b_q];

  // Rotating the doubled word keeps a zero shift an exact identity.
  assign rot_wide = {alu_a, alu_a} >> shamt_q;

  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OpXor:   alu_res = alu_a ^ alu_b;
      OpAnd:   alu_res = alu_a & alu_b;
      OpOr:    alu_res = alu_a | alu_b;
      default: alu_res = rot_wide[HVDimension-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d = StExec;
          cnt_d   = '0;
        end
      end
      StExec: begin
        if (last_iter) begin
          state_d = out_q ? StOut : StIdle;
        end else begin
          cnt_d = cnt_q + IterWidth'(1);
        end
      end
      StOut: begin
        if (res_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      shamt_q <= '0;
      iter_q  <= '0;
      out_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cmd_accept) begin
        op_q    <= cmd_op_i;
        src_a_q <= cmd_src_a_i;
        src_b_q <= cmd_src_b_i;
        dst_q   <= cmd_dst_i;
        shamt_q <= cmd_shift_amt_i;
        iter_q  <= cmd_iter_i;
        out_q   <= cmd_out_i;
      end
      // Snapshot keeps the streamed result stable even if software reloads dst.
      if (exec_we && last_iter) begin
        res_q <= alu_res;
      end
    end
  end

  // The EXEC write is issued after the load so it wins on a same-register collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (ld_valid_i) begin
        rf_q[ld_addr_i] <= ld_data_i;
      end
      if (exec_we) begin
        rf_q[dst_q] <= alu_res;
      end
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign res_valid_o = (state_q == StOut);
  assign res_data_o  = (state_q == StOut) ? res_q : '0;

endmodule

// File: tb/tb_hv_alu_ctrl.sv
// Directed bench for hv_alu_ctrl with an 8-bit datapath and 4 registers.
module tb_hv_alu_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned PW = 3;
  localparam int unsigned IW = 8;

  logic          clk, rst;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_a, cmd_b, cmd_d;
  logic [PW-1:0] cmd_sh;
  logic [IW-1:0] cmd_it;
  logic          cmd_out;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_data;
  logic          busy;

  int tests = 0;
  int fails = 0;

  hv_alu_ctrl #(
    .HVDimension(W),
    .NumRegs    (4),
    .MaxShiftAmt(8),
    .IterWidth  (IW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ld_valid_i     (ld_valid),
    .ld_addr_i      (ld_addr),
    .ld_data_i      (ld_data),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_op_i       (cmd_op),
    .cmd_src_a_i    (cmd_a),
    .cmd_src_b_i    (cmd_b),
    .cmd_dst_i      (cmd_d),
    .cmd_shift_amt_i(cmd_sh),
    .cmd_iter_i     (cmd_it),
    .cmd_out_i      (cmd_out),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic [PW-1:0] sh,
                         input logic [IW-1:0] it, input logic out);
    cmd_op  = op;
    cmd_a   = a;
    cmd_b   = b;
    cmd_d   = d;
    cmd_sh  = sh;
    cmd_it  = it;
    cmd_out = out;
  endtask

  // Waits (bounded) for res_valid; lat counts cycles since the accepting edge.
  task automatic wait_result(output logic [W-1:0] res, output int lat, output int bcnt,
                             output logic bafter);
    lat  = 1;
    bcnt = 0;
    while (!res_valid && lat < 400) begin
      bcnt += int'(busy);
      step();
      lat++;
    end
    bcnt += int'(busy);
    res       = res_data;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    bafter    = busy;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic [PW-1:0] sh,
                         input logic [IW-1:0] it, output logic [W-1:0] res, output int lat,
                         output int bcnt, output logic bafter);
    set_cmd(op, a, b, d, sh, it, 1'b1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_result(res, lat, bcnt, bafter);
  endtask

  logic [W-1:0] r;
  int           lat, bcnt;
  logic         bafter;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    tests++; if (res_data !== 8'h00) begin fails++; $display("FAIL reset_res_data got %h want 00", res_data); end
    rst = 1'b0;
    step();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_xor();
    load(2'd0, 8'hA5);
    load(2'd1, 8'h0F);
    run_cmd(2'd0, 2'd0, 2'd1, 2'd2, 3'd0, 8'd0, r, lat, bcnt, bafter);
    tests++; if (r !== 8'hAA) begin fails++; $display("FAIL xor_result got %h want aa", r); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL xor_latency got %0d want 2", lat); end
    run_cmd(2'd2, 2'd2, 2'd2, 2'd2, 3'd0, 8'd0, r, lat, bcnt, bafter);
    tests++; if (r !== 8'hAA) begin fails++; $display("FAIL xor_reg2_readback got %h want aa", r); end
  endtask

  task automatic test_shift_iter();
    load(2'd0, 8'h01);
    run_cmd(2'd3, 2'd0, 2'd0, 2'd3, 3'd1, 8'd3, r, lat, bcnt, bafter);
    tests++; if (r !== 8'h10) begin fails++; $display("FAIL shift_iter_result got %h want 10", r); end
    tests++; if (lat !== 5) begin fails++; $display("FAIL shift_iter_latency got %0d want 5", lat); end
    tests++; if (bcnt !== 5) begin fails++; $display("FAIL shift_iter_busy_cycles got %0d want 5", bcnt); end
    tests++; if (bafter !== 1'b0) begin fails++; $display("FAIL shift_iter_busy_after got %b want 0", bafter); end
    // 256 single-bit rotations of an 8-bit word return the original value.
    load(2'd0, 8'h3A);
    run_cmd(2'd3, 2'd0, 2'd0, 2'd1, 3'd1, 8'hFF, r, lat, bcnt, bafter);
    tests++; if (r !== 8'h3A) begin fails++; $display("FAIL max_iter_result got %h want 3a", r); end
    tests++; if (lat !== 257) begin fails++; $display("FAIL max_iter_latency got %0d want 257", lat); end
  endtask

  task automatic test_ops();
    load(2'd0, 8'h81);
    run_cmd(2'd3, 2'd0, 2'd0, 2'd1, 3'd0, 8'd0, r, lat, bcnt, bafter);
    tests++; if (r !== 8'h81) begin fails++; $display("FAIL shift0_result got %h want 81", r); end
    load(2'd0, 8'h96);
    run_cmd(2'd3, 2'd0, 2'd0, 2'd1, 3'd3, 8'd0, r, lat, bcnt, bafter);
    tests++; if (r !== 8'hD2) begin fails++; $display("FAIL shift3_result got %h want d2", r); end
    load(2'd0, 8'hF0);
    load(2'd1, 8'h3C);
    run_cmd(2'd1, 2'd0, 2'd1, 2'd2, 3'd0, 8'd0, r, lat, bcnt, bafter);
    tests++; if (r !== 8'h30) begin fails++; $display("FAIL and_result got %h want 30", r); end
    // F0^3C=CC, CC^3C=F0, F0^3C=CC
    run_cmd(2'd0, 2'd0, 2'd1, 2'd2, 3'd0, 8'd2, r, lat, bcnt, bafter);
    tests++; if (r !== 8'hCC) begin fails++; $display("FAIL xor_iter_result got %h want cc", r); end
    tests++; if (lat !== 4) begin fails++; $display("FAIL xor_iter_latency got %0d want 4", lat); end
    load(2'd1, 8'h0C);
    run_cmd(2'd2, 2'd0, 2'd1, 2'd3, 3'd0, 8'd0, r, lat, bcnt, bafter);
    tests++; if (r !== 8'hFC) begin fails++; $display("FAIL or_result got %h want fc", r); end
  endtask

  task automatic test_hold_and_back_to_back();
    load(2'd0, 8'hA5);
    load(2'd1, 8'h0F);
    set_cmd(2'd0, 2'd0, 2'd1, 2'd2, 3'd0, 8'd0, 1'b1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d] got %b want 1", i, res_valid); end
      tests++; if (res_data !== 8'hAA) begin fails++; $display("FAIL hold_data[%0d] got %h want aa", i, res_data); end
      tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL hold_cmd_ready[%0d] got %b want 0", i, cmd_ready); end
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL release_valid got %b want 0", res_valid); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL release_cmd_ready got %b want 1", cmd_ready); end
    run_cmd(2'd2, 2'd2, 2'd2, 2'd2, 3'd0, 8'd0, r, lat, bcnt, bafter);
    tests++; if (r !== 8'hAA) begin fails++; $display("FAIL back_to_back_result got %h want aa", r); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL back_to_back_latency got %0d want 2", lat); end
  endtask

  task automatic test_no_out();
    load(2'd0, 8'h33);
    load(2'd1, 8'h0F);
    set_cmd(2'd0, 2'd0, 2'd1, 2'd3, 3'd0, 8'd1, 1'b0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL no_out_ready_t1 got %b want 0", cmd_ready); end
    step();
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL no_out_ready_t2 got %b want 0", cmd_ready); end
    step();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL no_out_ready_t3 got %b want 1", cmd_ready); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL no_out_valid got %b want 0", res_valid); end
    // 33^0F=3C, 3C^0F=33
    run_cmd(2'd2, 2'd3, 2'd3, 2'd3, 3'd0, 8'd0, r, lat, bcnt, bafter);
    tests++; if (r !== 8'h33) begin fails++; $display("FAIL no_out_readback got %h want 33", r); end
  endtask

  task automatic test_load_hazards();
    load(2'd0, 8'h0F);
    ld_valid = 1'b1;
    ld_addr  = 2'd1;
    ld_data  = 8'hFF;
    set_cmd(2'd0, 2'd0, 2'd1, 2'd2, 3'd0, 8'd0, 1'b1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    ld_valid  = 1'b0;
    wait_result(r, lat, bcnt, bafter);
    tests++; if (r !== 8'hF0) begin fails++; $display("FAIL same_cycle_load got %h want f0", r); end
    // Load hammers dst during all three EXEC cycles; EXEC writes must win.
    set_cmd(2'd0, 2'd0, 2'd1, 2'd2, 3'd0, 8'd2, 1'b1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    ld_valid  = 1'b1;
    ld_addr   = 2'd2;
    ld_data   = 8'h55;
    repeat (3) step();
    ld_valid = 1'b0;
    wait_result(r, lat, bcnt, bafter);
    tests++; if (r !== 8'hF0) begin fails++; $display("FAIL exec_wins_result got %h want f0", r); end
    run_cmd(2'd2, 2'd2, 2'd2, 2'd2, 3'd0, 8'd0, r, lat, bcnt, bafter);
    tests++; if (r !== 8'hF0) begin fails++; $display("FAIL exec_wins_readback got %h want f0", r); end
  endtask

  task automatic test_reset_mid_exec();
    load(2'd0, 8'h01);
    load(2'd3, 8'h77);
    set_cmd(2'd3, 2'd0, 2'd0, 2'd1, 3'd1, 8'd10, 1'b1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (2) step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pre_reset_busy got %b want 1", busy); end
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_reset_busy got %b want 0", busy); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL async_reset_valid got %b want 0", res_valid); end
    tests++; if (res_data !== 8'h00) begin fails++; $display("FAIL async_reset_data got %h want 00", res_data); end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL async_reset_ready got %b want 1", cmd_ready); end
    repeat (2) step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      run_cmd(2'd0, 2'(i), 2'd0, 2'(i), 3'd0, 8'd0, r, lat, bcnt, bafter);
      tests++; if (r !== 8'h00) begin fails++; $display("FAIL post_reset_reg%0d got %h want 00", i, r); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    set_cmd(2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 8'd0, 1'b0);
    test_reset();
    test_xor();
    test_shift_iter();
    test_ops();
    test_hold_and_back_to_back();
    test_no_out();
    test_load_hazards();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
